// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // OR-reduction of set positions; exact for one-hot inputs, 0 for all-zero.
  function automatic logic [4:0] onehot2bin(input logic [31:0] oh);
    logic [4:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) b = b | 5'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_mask_pick.sv
// Pointer-masked fixed-priority pick: lowest request at or above ptr, else lowest request.
module rr_mask_pick
  import rr_arb_pkg::*;
#(
  parameter  int NUM  = 4,
  localparam int ID_W = $clog2(NUM)
) (
  input  logic [NUM-1:0]  req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NUM-1:0]  win_oh_o,
  output logic [ID_W-1:0] win_id_o
);

  logic [NUM-1:0] mask;
  logic [NUM-1:0] masked;
  logic [NUM-1:0] sel;

  always_comb begin
    mask     = {NUM{1'b1}} << ptr_i;
    masked   = req_i & mask;
    sel      = (|masked) ? masked : req_i;
    // Two's-complement trick isolates the lowest set bit.
    win_oh_o = sel & (~sel + NUM'(1));
    win_id_o = ID_W'(onehot2bin(32'(win_oh_o)));
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter holding a registered one-hot grant for a whole burst of beats.
module rr_burst_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int NUM   = 4,
  parameter  int LEN_W = 4,
  localparam int ID_W  = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM-1:0]       req,
  input  logic [NUM*LEN_W-1:0] req_len,
  input  logic                 beat_done,
  output logic [NUM-1:0]       gnt,
  output logic [ID_W-1:0]      gnt_id,
  output logic                 gnt_vld,
  output logic                 last_beat,
  output state_e               dbg_state_o,
  output logic [ID_W-1:0]      dbg_ptr_o
);

  // Handshake: a grant, once loaded, is held until beat_done has been seen
  // cnt+1 times; req changes during BUSY are ignored (burst lock).
  state_e             state_q;
  logic [NUM-1:0]     gnt_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [ID_W-1:0]    ptr_q;

  logic               burst_end;
  logic [ID_W-1:0]    ptr_d;
  logic [NUM-1:0]     win_oh;
  logic [ID_W-1:0]    win_id;
  logic [LEN_W-1:0]   win_len;

  assign burst_end = (state_q == BUSY) && beat_done && (cnt_q == '0);

  // The pick sees the post-completion pointer so back-to-back grants rotate correctly.
  always_comb begin
    ptr_d = ptr_q;
    if (burst_end) begin
      ptr_d = (gnt_id_q == ID_W'(NUM - 1)) ? '0 : gnt_id_q + ID_W'(1);
    end
  end

  rr_mask_pick #(.NUM(NUM)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_d),
    .win_oh_o (win_oh),
    .win_id_o (win_id)
  );

  assign win_len = req_len[win_id*LEN_W +: LEN_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
    end else begin
      ptr_q <= ptr_d;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q  <= BUSY;
            gnt_q    <= win_oh;
            gnt_id_q <= win_id;
            cnt_q    <= win_len;
          end
        end
        BUSY: begin
          if (beat_done) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - LEN_W'(1);
            end else if (|req) begin
              gnt_q    <= win_oh;
              gnt_id_q <= win_id;
              cnt_q    <= win_len;
            end else begin
              state_q  <= IDLE;
              gnt_q    <= '0;
              gnt_id_q <= '0;
              cnt_q    <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign gnt_vld     = (state_q == BUSY);
  assign last_beat   = gnt_vld && (cnt_q == '0);
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: vector table plus an async-reset sequence.
module tb_rr_burst_arbiter;
  import rr_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic        beat_done;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        gnt_vld;
  logic        last_beat;
  state_e      dbg_state;
  logic [1:0]  dbg_ptr;

  int tests;
  int fails;

  rr_burst_arbiter #(.NUM(4), .LEN_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_len     (req_len),
    .beat_done   (beat_done),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .gnt_vld     (gnt_vld),
    .last_beat   (last_beat),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    logic        bd;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic        vld;
    logic        last;
    logic [1:0]  ptr;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                           input logic e_vld, input logic e_last, input logic [1:0] e_ptr);
    check({tag, " gnt"},       32'(gnt),       32'(e_gnt));
    check({tag, " gnt_id"},    32'(gnt_id),    32'(e_id));
    check({tag, " gnt_vld"},   32'(gnt_vld),   32'(e_vld));
    check({tag, " last_beat"}, 32'(last_beat), 32'(e_last));
    check({tag, " ptr"},       32'(dbg_ptr),   32'(e_ptr));
    check({tag, " state"},     32'(dbg_state), e_vld ? 32'(BUSY) : 32'(IDLE));
  endtask

  task automatic step(input logic [3:0] r, input logic [15:0] l, input logic bd);
    req       = r;
    req_len   = l;
    beat_done = bd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    req       = 4'b1111;
    req_len   = 16'h0000;
    beat_done = 1'b0;

    // req, len, bd | gnt, id, vld, last, ptr (values after the edge)
    vq.push_back('{4'b0100, 16'h0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, 2'd0});
    vq.push_back('{4'b0000, 16'h0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd3});
    vq.push_back('{4'b0000, 16'h0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd3});
    vq.push_back('{4'b1001, 16'h0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 2'd3});
    vq.push_back('{4'b1001, 16'h0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 2'd0});
    vq.push_back('{4'b1111, 16'h0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd1});
    vq.push_back('{4'b1111, 16'h0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 2'd2});
    vq.push_back('{4'b1111, 16'h0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 2'd3});
    vq.push_back('{4'b1111, 16'h0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 2'd0});
    vq.push_back('{4'b0000, 16'h0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd1});
    vq.push_back('{4'b0010, 16'h0030, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1});
    vq.push_back('{4'b0001, 16'h0030, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1});
    vq.push_back('{4'b0001, 16'h0030, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1});
    vq.push_back('{4'b0001, 16'h0030, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1});
    vq.push_back('{4'b0001, 16'h0030, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1});
    vq.push_back('{4'b0001, 16'h0030, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd1});
    vq.push_back('{4'b0001, 16'h0030, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd1});
    vq.push_back('{4'b0001, 16'h0030, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 2'd2});
    vq.push_back('{4'b0000, 16'h0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd1});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);

    rst_n = 1'b1;
    foreach (vq[i]) begin
      step(vq[i].req, vq[i].len, vq[i].bd);
      check_all($sformatf("v%0d", i), vq[i].gnt, vq[i].id, vq[i].vld, vq[i].last, vq[i].ptr);
    end

    // Async reset in the middle of an 8-beat burst for requester 2 (ptr is 1 here).
    step(4'b0100, 16'h0700, 1'b0);
    check_all("ar_grant", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1);
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 16'h0700, 1'b1);
      check_all($sformatf("ar_beat%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1);
    end
    beat_done = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("ar_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0110, 16'h0000, 1'b0);
    check_all("ar_after", 4'b0010, 2'd1, 1'b1, 1'b1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
